// File: rtl/cpu_clk_sched.sv
// Run-control scheduler: programmable clock divider plus HALT/RUN/STEP FSM that gates a one-cycle cpu_en.
// Optional: define CPU_EN_COUNT_EN to add a 32-bit en_count output counting cpu_en pulses since reset.
module cpu_clk_sched #(
  parameter int DIV_W   = 17,
  parameter int DEF_DIV = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DIV_W-1:0] cmd_arg,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
`ifdef CPU_EN_COUNT_EN
  ,
  output logic [31:0]      en_count
`endif
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_HALT   = 2'b00,
    OP_RUN    = 2'b01,
    OP_STEP   = 2'b10,
    OP_SETDIV = 2'b11
  } cmd_op_e;

  state_e           state_q;
  cmd_op_e          op;
  logic [DIV_W-1:0] q_q, q_d;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] steps_q;
  logic [CNT_W-1:0] step_n;
  logic             cpu_en_q, cpu_en_d;
  logic             done_q;
  logic             tick;
  logic             accept;
  logic             restart;

  assign op     = cmd_op_e'(cmd_op);
  assign step_n = cmd_arg[CNT_W-1:0];
  assign tick   = (q_q == div_q - DIV_W'(1));

  // A breakpoint blocks command acceptance; STEP runs to completion unless aborted.
  assign cmd_ready = ~halt_req & (state_q != ST_STEP);
  assign accept    = cmd_valid & cmd_ready;
  assign restart   = accept & (op != OP_HALT);

  // The tick is judged against the old state, except a HALT accepted in RUN suppresses it.
  assign cpu_en_d = tick & ~halt_req &
                    ((state_q == ST_STEP) |
                     ((state_q == ST_RUN) & ~(accept & (op == OP_HALT))));

  always_comb begin
    // NOTE: assign a default first so every path drives q_d and no latch is inferred.
    q_d = q_q + DIV_W'(1);
    if (restart || tick) begin
      q_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_HALT;
      q_q      <= '0;
      div_q    <= DIV_W'(DEF_DIV);
      steps_q  <= '0;
      cpu_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      cpu_en_q <= cpu_en_d;
      done_q   <= 1'b0;
      if (halt_req) begin
        if (state_q == ST_STEP) begin
          done_q <= 1'b1;
        end
        state_q <= ST_HALT;
        steps_q <= '0;
      end else begin
        if (state_q == ST_STEP && tick) begin
          steps_q <= steps_q - CNT_W'(1);
          if (steps_q == CNT_W'(1)) begin
            state_q <= ST_HALT;
            done_q  <= 1'b1;
          end
        end
        if (accept) begin
          case (op)
            OP_HALT: state_q <= ST_HALT;
            OP_RUN:  state_q <= ST_RUN;
            OP_STEP: begin
              if (step_n == '0) begin
                state_q <= ST_HALT;
                steps_q <= '0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_STEP;
                steps_q <= step_n;
              end
            end
            OP_SETDIV: div_q <= (cmd_arg == '0) ? DIV_W'(1) : cmd_arg;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef CPU_EN_COUNT_EN
  logic [31:0] en_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_count_q <= '0;
    end else if (cpu_en_d) begin
      en_count_q <= en_count_q + 32'd1;
    end
  end

  assign en_count = en_count_q;
`endif

  assign cpu_en     = cpu_en_q;
  assign state      = state_q;
  assign done       = done_q;
  assign steps_left = steps_q;

endmodule

// File: tb/tb_cpu_clk_sched.sv
// Self-checking bench for cpu_clk_sched: vector tables, hand-written corner sequences, and random traffic
// compared against a cycle-count model of the divider and run-control rules.
module tb_cpu_clk_sched;

  localparam logic [1:0] S_HALT = 2'b00, S_RUN = 2'b01, S_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b00, OP_RUN = 2'b01, OP_STEP = 2'b10, OP_SETDIV = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [16:0] cmd_arg;
  logic        halt_req;
  logic        cpu_en;
  logic [1:0]  state;
  logic        done;
  logic [15:0] steps_left;
`ifdef CPU_EN_COUNT_EN
  logic [31:0] en_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  cpu_clk_sched #(.DIV_W(17), .DEF_DIV(4), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .halt_req   (halt_req),
    .cpu_en     (cpu_en),
    .state      (state),
    .done       (done),
    .steps_left (steps_left)
`ifdef CPU_EN_COUNT_EN
    ,
    .en_count   (en_count)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: the divider phase is derived from absolute edge counts, not a counter register.
  int          m_state;
  int          m_steps;
  longint      m_div;
  longint      m_t0;
  longint      m_edge;
  bit          m_en;
  bit          m_done;
  logic [31:0] m_cnt;

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [16:0] arg;
    logic        halt;
    logic [1:0]  st;
    logic        en;
    logic        dn;
    logic [15:0] sl;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] pack(input logic [1:0] st, input logic en, input logic dn,
                                       input logic [15:0] sl, input logic rdy);
    return {43'd0, st, en, dn, sl, rdy};
  endfunction

  function automatic logic [63:0] dut_pack();
    return pack(state, cpu_en, done, steps_left, cmd_ready);
  endfunction

  function automatic logic [63:0] model_pack();
    logic rdy;
    rdy = !halt_req && (m_state != int'(S_STEP));
    return pack(m_state[1:0], m_en, m_done, m_steps[15:0], rdy);
  endfunction

  task automatic model_reset();
    m_state = int'(S_HALT);
    m_steps = 0;
    m_div   = 4;
    m_t0    = 0;
    m_edge  = 0;
    m_en    = 0;
    m_done  = 0;
    m_cnt   = '0;
  endtask

  task automatic model_edge();
    bit rdy, acc, tick;
    rdy  = !halt_req && (m_state != int'(S_STEP));
    acc  = cmd_valid && rdy;
    tick = ((m_edge - m_t0) % m_div) == (m_div - 1);
    m_en   = 0;
    m_done = 0;
    if (halt_req) begin
      m_done  = (m_state == int'(S_STEP));
      m_state = int'(S_HALT);
      m_steps = 0;
    end else begin
      if (m_state == int'(S_RUN)) begin
        m_en = tick && !(acc && cmd_op == OP_HALT);
      end else if (m_state == int'(S_STEP) && tick) begin
        m_en = 1;
        m_steps--;
        if (m_steps == 0) begin
          m_state = int'(S_HALT);
          m_done  = 1;
        end
      end
      if (acc) begin
        case (cmd_op)
          OP_HALT: m_state = int'(S_HALT);
          OP_RUN:  m_state = int'(S_RUN);
          OP_STEP: begin
            if (cmd_arg[15:0] == 16'd0) begin
              m_state = int'(S_HALT);
              m_steps = 0;
              m_done  = 1;
            end else begin
              m_state = int'(S_STEP);
              m_steps = int'(cmd_arg[15:0]);
            end
          end
          default: m_div = (cmd_arg == 17'd0) ? 1 : longint'(cmd_arg);
        endcase
        if (cmd_op != OP_HALT) m_t0 = m_edge + 1;
      end
    end
    m_edge++;
    if (m_en) m_cnt++;
  endtask

  // Drive inputs, advance the model, then return 1 time unit after the clock edge.
  task automatic apply(input logic v, input logic [1:0] op, input logic [16:0] arg, input logic h);
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = arg;
    halt_req  = h;
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, OP_HALT, 17'd0, 1'b0);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    cmd_op    = OP_HALT;
    cmd_arg   = '0;
    halt_req  = 1'b0;
    reset     = 1'b1;
    #2;
    check("reset_values", dut_pack(), pack(S_HALT, 1'b0, 1'b0, 16'd0, 1'b1));
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic fill_vectors();
    vec_t v;
    for (int i = 0; i < 15; i++) begin
      v.valid = (i == 0) || (i == 10);
      v.op    = (i == 0) ? OP_RUN : OP_HALT;
      v.arg   = '0;
      v.halt  = 1'b0;
      v.st    = (i < 10) ? S_RUN : S_HALT;
      v.en    = (i == 4) || (i == 8);
      v.dn    = 1'b0;
      v.sl    = '0;
      v.rdy   = 1'b1;
      vecs.push_back(v);
    end
    for (int i = 0; i < 14; i++) begin
      v.valid = (i == 0);
      v.op    = OP_STEP;
      v.arg   = 17'd3;
      v.halt  = 1'b0;
      v.st    = (i < 12) ? S_STEP : S_HALT;
      v.en    = (i == 4) || (i == 8) || (i == 12);
      v.dn    = (i == 12);
      v.sl    = (i < 4) ? 16'd3 : (i < 8) ? 16'd2 : (i < 12) ? 16'd1 : 16'd0;
      v.rdy   = (i >= 12);
      vecs.push_back(v);
    end
    // STEP with N==0 finishes immediately with done and no enable.
    v.valid = 1'b1; v.op = OP_STEP; v.arg = 17'd0; v.halt = 1'b0;
    v.st = S_HALT; v.en = 1'b0; v.dn = 1'b1; v.sl = '0; v.rdy = 1'b1;
    vecs.push_back(v);
    v.valid = 1'b0; v.dn = 1'b0;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] pat;
    int         n_en, n_dn;
    bit         seen;

    reset = 1'b0;
    fill_vectors();
    do_reset();

    // Idle after reset: nothing may move.
    for (int i = 0; i < 20; i++) begin
      idle();
      check($sformatf("idle_c%0d", i), dut_pack(), pack(S_HALT, 1'b0, 1'b0, 16'd0, 1'b1));
    end

    foreach (vecs[i]) begin
      apply(vecs[i].valid, vecs[i].op, vecs[i].arg, vecs[i].halt);
      check($sformatf("vec%0d", i), dut_pack(),
            pack(vecs[i].st, vecs[i].en, vecs[i].dn, vecs[i].sl, vecs[i].rdy));
    end

    // Divisor 0 behaves as 1, then SET_DIV 2 in the middle of RUN.
    apply(1'b1, OP_SETDIV, 17'd0, 1'b0);
    apply(1'b1, OP_RUN, 17'd0, 1'b0);
    check("div1_first_edge_en", cpu_en, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check($sformatf("div1_en_c%0d", i), cpu_en, 1'b1);
    end
    apply(1'b1, OP_SETDIV, 17'd2, 1'b0);
    check("setdiv_edge_en", cpu_en, 1'b1);
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      idle();
      pat[i] = cpu_en;
    end
    check("div2_pattern", pat, 4'b1010);
    check("div2_state", state, S_RUN);

    // STEP 10 aborted by a breakpoint after two enables.
    apply(1'b1, OP_HALT, 17'd0, 1'b0);
    apply(1'b1, OP_SETDIV, 17'd4, 1'b0);
    apply(1'b1, OP_STEP, 17'd10, 1'b0);
    n_en = 0;
    for (int i = 1; i <= 8; i++) begin
      idle();
      if (cpu_en) n_en++;
    end
    check("step10_two_enables", n_en, 2);
    check("step10_steps_left", steps_left, 16'd8);
    cmd_valid = 1'b1;
    cmd_op    = OP_RUN;
    halt_req  = 1'b1;
    #1;
    check("halt_req_blocks_ready", cmd_ready, 1'b0);
    apply(1'b1, OP_RUN, 17'd0, 1'b1);
    check("halt_req_abort", dut_pack(), pack(S_HALT, 1'b0, 1'b1, 16'd0, 1'b0));
    n_en = 0;
    n_dn = 0;
    for (int i = 0; i < 12; i++) begin
      idle();
      if (cpu_en) n_en++;
      if (done) n_dn++;
    end
    check("after_abort_en", n_en, 0);
    check("after_abort_done", n_dn, 0);
    check("after_abort_state", state, S_HALT);

    // Asynchronous reset in the middle of a RUN pulse.
    apply(1'b1, OP_SETDIV, 17'd2, 1'b0);
    apply(1'b1, OP_RUN, 17'd0, 1'b0);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      idle();
      seen = cpu_en;
    end
    check("pre_reset_pulse", seen, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_drop", dut_pack(), pack(S_HALT, 1'b0, 1'b0, 16'd0, 1'b1));
`ifdef CPU_EN_COUNT_EN
    check("async_reset_count", en_count, 32'd0);
`endif
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    apply(1'b1, OP_RUN, 17'd0, 1'b0);
    check("post_reset_run_edge", cpu_en, 1'b0);
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      idle();
      pat[i] = cpu_en;
    end
    check("post_reset_div4", pat, 4'b1000);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic        v, h;
      logic [1:0]  op;
      logic [16:0] arg;
      v  = ($urandom_range(0, 2) == 0);
      op = 2'($urandom_range(0, 3));
      h  = ($urandom_range(0, 24) == 0);
      if (op == OP_SETDIV) arg = 17'($urandom_range(0, 5));
      else if (op == OP_STEP) arg = 17'($urandom_range(0, 4)) | (17'($urandom_range(0, 1)) << 16);
      else arg = 17'($urandom);
      apply(v, op, arg, h);
      check($sformatf("rand_c%0d", c), dut_pack(), model_pack());
`ifdef CPU_EN_COUNT_EN
      check($sformatf("rand_cnt_c%0d", c), en_count, m_cnt);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
